// File: rtl/seg_scan.sv
// Multiplexed hex display scanner with PWM brightness, leading-zero blanking
// and double-buffered data that the active copy only takes at frame boundaries.
module seg_scan #(
  parameter int NDIG           = 8,
  parameter int SCAN_DIV       = 1024,
  parameter int SEL_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [4*NDIG-1:0] data,
  input  logic [NDIG-1:0]   dp,
  input  logic              load,
  input  logic              blank_lz,
  input  logic [3:0]        bright,
  output logic [NDIG-1:0]   sel,
  output logic [7:0]        segment,
  output logic              frame_done
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = $clog2(NDIG);
  localparam logic SEL_INV = (SEL_ACTIVE_LOW != 0);
  localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);

  logic [PW-1:0]     presc;
  logic [3:0]        step;
  logic [IW-1:0]     idx;
  logic [4*NDIG-1:0] shadow_data, act_data;
  logic [NDIG-1:0]   shadow_dp, act_dp;

  logic              pre_tc, step_tc, wrap, lit;
  logic [NDIG-1:0]   blank;
  logic              zero_run;
  int unsigned       nib_pos;
  logic [3:0]        nibble;
  logic [NDIG-1:0]   sel_int;
  logic [7:0]        seg_int;

  function automatic logic [6:0] hex_font(input logic [3:0] n);
    case (n)
      4'h0: hex_font = 7'h3F;
      4'h1: hex_font = 7'h06;
      4'h2: hex_font = 7'h5B;
      4'h3: hex_font = 7'h4F;
      4'h4: hex_font = 7'h66;
      4'h5: hex_font = 7'h6D;
      4'h6: hex_font = 7'h7D;
      4'h7: hex_font = 7'h07;
      4'h8: hex_font = 7'h7F;
      4'h9: hex_font = 7'h6F;
      4'hA: hex_font = 7'h77;
      4'hB: hex_font = 7'h7C;
      4'hC: hex_font = 7'h39;
      4'hD: hex_font = 7'h5E;
      4'hE: hex_font = 7'h79;
      default: hex_font = 7'h71;
    endcase
  endfunction

  assign pre_tc  = (presc == PW'(SCAN_DIV - 1));
  assign step_tc = pre_tc && (step == 4'hF);
  assign wrap    = step_tc && (idx == IW'(NDIG - 1));
  assign lit     = (step <= bright);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      step  <= '0;
      idx   <= '0;
    end else begin
      presc <= pre_tc ? '0 : presc + 1'b1;
      if (pre_tc) step <= step + 1'b1;
      if (step_tc) idx <= wrap ? '0 : idx + 1'b1;
    end
  end

  // A load landing on the wrap cycle bypasses the shadow so it shows next frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_data <= '0;
      shadow_dp   <= '0;
      act_data    <= '0;
      act_dp      <= '0;
    end else begin
      if (load) begin
        shadow_data <= data;
        shadow_dp   <= dp;
      end
      if (wrap) begin
        act_data <= load ? data : shadow_data;
        act_dp   <= load ? dp   : shadow_dp;
      end
    end
  end

  always_comb begin
    zero_run = 1'b1;
    blank    = '0;
    for (int k = NDIG - 1; k >= 0; k--) begin
      zero_run = zero_run && (act_data[4*k +: 4] == 4'h0);
      if (k != 0) blank[k] = blank_lz && zero_run;
    end
  end

  always_comb begin
    nib_pos = NDIG - 1 - int'(idx);
    nibble  = act_data[4*nib_pos +: 4];
    sel_int = '0;
    seg_int = '0;
    for (int i = 0; i < NDIG; i++) sel_int[i] = lit && (idx == IW'(i));
    if (lit) begin
      seg_int[7]   = act_dp[nib_pos];
      seg_int[6:0] = blank[nib_pos] ? 7'h00 : hex_font(nibble);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel        <= {NDIG{SEL_INV}};
      segment    <= {8{SEG_INV}};
      frame_done <= 1'b0;
    end else begin
      sel        <= sel_int ^ {NDIG{SEL_INV}};
      segment    <= seg_int ^ {8{SEG_INV}};
      frame_done <= wrap;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// Directed bench for seg_scan with NDIG=4, SCAN_DIV=2: 32-clock slots, 128-clock frames.
module tb_seg_scan;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] data;
  logic [3:0]  dp;
  logic        load;
  logic        blank_lz;
  logic [3:0]  bright;
  logic [3:0]  sel;
  logic [7:0]  segment;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  seg_scan #(
    .NDIG(4),
    .SCAN_DIV(2),
    .SEL_ACTIVE_LOW(1),
    .SEG_ACTIVE_LOW(0)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data(data),
    .dp(dp),
    .load(load),
    .blank_lz(blank_lz),
    .bright(bright),
    .sel(sel),
    .segment(segment),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p);
    data = d;
    dp   = p;
    load = 1'b1;
    @(posedge clk); #1;
    load = 1'b0;
  endtask

  task automatic waitFrame(input string tag);
    int n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      n++;
      if (frame_done) break;
    end
    if (n >= 300) checkOutput({tag, "_timeout"}, 32'(n), 32'd0);
  endtask

  // Called in a cycle where the counters are all zero; samples each digit at
  // lit_step (and optionally dark_step) and returns on the next frame_done cycle.
  task automatic runFrame(input string tag, input logic [31:0] exp_seg, input int lit_step, input int dark_step);
    int d = 0;
    logic [3:0] es;
    while (d < 200) begin
      @(posedge clk); #1;
      d++;
      for (int k = 0; k < 4; k++) begin
        es = ~(4'b0001 << k);
        if (d == 1 + 32*k + 2*lit_step + 1) begin
          checkOutput($sformatf("%s_sel%0d", tag, k), 32'(sel), 32'(es));
          checkOutput($sformatf("%s_seg%0d", tag, k), 32'(segment), 32'(exp_seg[8*k +: 8]));
        end
        if (dark_step >= 0 && d == 1 + 32*k + 2*dark_step) begin
          checkOutput($sformatf("%s_dsel%0d", tag, k), 32'(sel), 32'h0000000F);
          checkOutput($sformatf("%s_dseg%0d", tag, k), 32'(segment), 32'h00000000);
        end
      end
      if (frame_done) break;
    end
    checkOutput({tag, "_period"}, 32'(d), 32'd128);
  endtask

  initial begin
    logic [3:0] es;
    rst_n    = 1'b0;
    data     = '0;
    dp       = '0;
    load     = 1'b0;
    blank_lz = 1'b0;
    bright   = 4'd15;

    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_sel", 32'(sel), 32'h0000000F);
    checkOutput("rst_seg", 32'(segment), 32'h00000000);
    checkOutput("rst_fd", 32'(frame_done), 32'd0);
    rst_n = 1'b1;
    runFrame("zero", 32'h3F3F3F3F, 2, -1);

    $display("[TB] hex font and scan order");
    applyStimulus(16'h12AF, 4'b0000);
    waitFrame("load12af");
    runFrame("hex", 32'h71775B06, 2, -1);

    bright = 4'd3;
    runFrame("dim", 32'h71775B06, 3, 4);
    bright = 4'd15;

    $display("[TB] leading-zero blanking");
    blank_lz = 1'b1;
    applyStimulus(16'h0050, 4'b0100);
    waitFrame("load0050");
    runFrame("blank", 32'h3F6D8000, 2, -1);
    blank_lz = 1'b0;
    runFrame("noblank", 32'h3F6DBF3F, 2, -1);
    blank_lz = 1'b1;
    applyStimulus(16'h0000, 4'b0000);
    waitFrame("load0000");
    runFrame("allzero", 32'h3F000000, 2, -1);
    blank_lz = 1'b0;

    $display("[TB] load on wrap bypasses shadow");
    begin
      int d = 0;
      while (d < 200) begin
        @(posedge clk); #1;
        d++;
        for (int k = 0; k < 4; k++) begin
          if (d == 1 + 32*k + 5)
            checkOutput($sformatf("hold_seg%0d", k), 32'(segment), 32'h0000003F);
        end
        if (d == 10) begin data = 16'h1111; load = 1'b1; end
        if (d == 11) load = 1'b0;
        if (d == 127) begin data = 16'h2222; load = 1'b1; end
        if (d == 128) load = 1'b0;
        if (frame_done) break;
      end
      checkOutput("hold_period", 32'(d), 32'd128);
    end
    runFrame("bypass", 32'h5B5B5B5B, 2, -1);
    runFrame("bypass2", 32'h5B5B5B5B, 15, -1);

    $display("[TB] asynchronous reset mid-slot");
    repeat (40) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_sel", 32'(sel), 32'h0000000F);
    checkOutput("arst_seg", 32'(segment), 32'h00000000);
    checkOutput("arst_fd", 32'(frame_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    es = 4'b1110;
    checkOutput("post_sel", 32'(sel), 32'(es));
    checkOutput("post_seg", 32'(segment), 32'h0000003F);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
